// File: rtl/universal_shift_register_pkg.sv
// rtl/universal_shift_register_pkg.sv - shared mode encodings for the universal shift register
package universal_shift_register_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'd0,
        MODE_SHL   = 3'd1,
        MODE_SHR   = 3'd2,
        MODE_ASR   = 3'd3,
        MODE_ROL   = 3'd4,
        MODE_ROR   = 3'd5,
        MODE_LOAD  = 3'd6,
        MODE_CLEAR = 3'd7
    } mode_e;

endpackage

// File: rtl/universal_shift_register_dff_bank.sv
// rtl/universal_shift_register_dff_bank.sv - enabled register bank with sync active-low reset
module dff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - universal shift register with shift counter and done pulse
module universal_shift_register
    import universal_shift_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [2:0]                   mode,
    input  logic                         sin,
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         sout,
    output logic [$clog2(WIDTH+1)-1:0]   cnt,
    output logic                         done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_d;
    logic             sout_d;
    logic [CW-1:0]    cnt_d;
    logic             done_d;
    logic             shift;
    logic [CW+1:0]    stat_q;

    assign {sout, cnt, done} = stat_q;

    always_comb begin
        q_d    = q;
        sout_d = sout;
        cnt_d  = cnt;
        done_d = 1'b0;
        shift  = 1'b0;
        if (en) begin
            case (mode_e'(mode))
                MODE_SHL:   begin q_d = {q[WIDTH-2:0], sin};      sout_d = q[WIDTH-1]; shift = 1'b1; end
                MODE_SHR:   begin q_d = {sin, q[WIDTH-1:1]};      sout_d = q[0];       shift = 1'b1; end
                MODE_ASR:   begin q_d = {q[WIDTH-1], q[WIDTH-1:1]}; sout_d = q[0];     shift = 1'b1; end
                MODE_ROL:   begin q_d = {q[WIDTH-2:0], q[WIDTH-1]}; sout_d = q[WIDTH-1]; shift = 1'b1; end
                MODE_ROR:   begin q_d = {q[0], q[WIDTH-1:1]};     sout_d = q[0];       shift = 1'b1; end
                MODE_LOAD:  begin q_d = d;  sout_d = 1'b0; cnt_d = '0; end
                MODE_CLEAR: begin q_d = '0; sout_d = 1'b0; cnt_d = '0; end
                default:    ;
            endcase
            // done fires only on the shift that crosses into a full word
            if (shift) begin
                cnt_d  = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
                done_d = (cnt == CNT_LAST);
            end
        end
    end

    dff_bank #(.WIDTH(WIDTH)) u_q_bank (
        .clk    (clk),
        .resetn (reset),
        .en     (en),
        .d      (q_d),
        .q      (q)
    );

    // status bank stays enabled so done can drop while en is low
    dff_bank #(.WIDTH(CW + 2)) u_stat_bank (
        .clk    (clk),
        .resetn (reset),
        .en     (1'b1),
        .d      ({sout_d, cnt_d, done_d}),
        .q      (stat_q)
    );

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock.
REQ-003 Port: reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 Port: en  input  1  operation enable; 0 = hold all state.
REQ-005 Port: mode  input  3  operation select (encodings in REQ-009).
REQ-006 Port: sin  input  1  serial input bit for logical shifts.
REQ-007 Port: d  input  WIDTH  parallel load data.
REQ-008 Port: q, output, WIDTH, register contents; sout, output, 1, last bit shifted or rotated out; cnt, output, $clog2(WIDTH+1), shifts since last load/clear; done, output, 1, one-cycle pulse on completion of a full-word serial transfer.

Function
REQ-009 On a rising clk with reset=1 and en=1, q SHALL update per mode: 000 hold; 001 SHL {q[W-2:0],sin}; 010 SHR {sin,q[W-1:1]}; 011 ASR {q[W-1],q[W-1:1]}; 100 ROL {q[W-2:0],q[W-1]}; 101 ROR {q[0],q[W-1:1]}; 110 LOAD d; 111 CLEAR to 0.
REQ-010 Latency: q, sout, cnt and done SHALL all be registered and reflect an operation one clk edge after it is sampled; no combinational path from inputs to outputs.
REQ-011 sout SHALL capture q[W-1] on SHL/ROL and q[0] on SHR/ASR/ROR; it is held on HOLD and set to 0 on LOAD/CLEAR.
REQ-012 Shift modes (001-101) SHALL increment cnt by 1, saturating at WIDTH.
REQ-013 LOAD and CLEAR SHALL set cnt to 0; HOLD leaves cnt unchanged.
REQ-014 done SHALL be 1 for exactly the one cycle following the edge on which cnt changes from WIDTH-1 to WIDTH; otherwise 0.
REQ-015 Shifts while cnt = WIDTH SHALL still update q and sout, keep cnt at WIDTH, and leave done 0.
REQ-016 en=0 SHALL hold q, sout and cnt regardless of mode and SHALL drive done to 0 on the next edge.
REQ-017 mode changes between shift kinds mid-sequence SHALL not reset cnt.

Reset
REQ-018 reset=0 at a rising clk edge SHALL force q=0, sout=0, cnt=0, done=0, taking priority over en and mode.
REQ-019 Reset asserted mid-sequence SHALL abort it: no done pulse is produced for the interrupted transfer.
REQ-020 Outputs SHALL be undefined-free from the first edge with reset=0; no asynchronous behaviour.

Structure
REQ-021 Mode encodings (MODE_HOLD..MODE_CLEAR) SHALL live as named constants in the shared project package; no literal mode codes in RTL.
REQ-022 State storage SHALL use one sub-module, dff_bank: parametrised WIDTH rising-edge register with enable and synchronous active-low reset, instantiated for q and for the {sout,cnt,done} status word.
REQ-023 Next-state selection SHALL be a single combinational block feeding dff_bank instances.

Verification
REQ-024 Reset: hold reset=0 for 5 cycles with en=1, mode=110, d=8'hFF -> q=8'h00, sout=0, cnt=0, done=0 throughout.
REQ-025 Load/shift: LOAD 8'hA5, then 8 x SHL with sin=0 -> q=8'h00; sout sequence 1,0,1,0,0,1,0,1; cnt reaches 8; done=1 on exactly the cycle after the 8th shift.
REQ-026 Arithmetic/rotate: LOAD 8'h81, ASR -> q=8'hC0, sout=1; then ROL -> q=8'h81, sout=1; then ROR -> q=8'hC0, sout=1.
REQ-027 Enable/saturation: LOAD 8'h3C, 4 x SHR, en=0 for 3 cycles with mode=111 -> q=8'h03 and cnt=4 held; 4 more SHR -> done pulse; 2 further SHR -> cnt stays 8, done stays 0.
REQ-028 Reset mid-operation: LOAD 8'hFF, 7 x ROL, reset=0 one cycle, then 1 x ROL -> q=8'h00, cnt=1, done never asserted.
REQ-029 Parameter sweep: repeat REQ-025 with WIDTH=2 and WIDTH=32 -> done after exactly WIDTH shifts; cnt width correct.
